rbsp_buffer: RTL and testbench
==============================

RBSP_BUFFER -- requirements
Module: rbsp_buffer

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 ena  input  1  global enable; when low, no state changes except reset.
REQ-004 nal_start  input  1  one-cycle pulse; discards buffer contents and begins a new NAL payload.
REQ-005 nalu_byte_in  input  8  next NAL payload byte, after the header, from read_nalu.
REQ-006 nalu_byte_valid  input  1  nalu_byte_in is valid.
REQ-007 nalu_byte_ready  output  1  byte accepted on a cycle where valid && ready && ena.
REQ-008 forward_len_in  input  5  bits consumed by the downstream parser this cycle; legal range 0..24.
REQ-009 rbsp_out  output  24  RBSP bit window; bit 23 is the next unconsumed bit.
REQ-010 rbsp_valid  output  1  high when at least 24 valid bits are held.
REQ-011 bit_level  output  6  number of valid bits held, 0..40.
REQ-012 protocol_err  output  1  sticky flag for an illegal forward request.

Function
REQ-013 Storage: one 40-bit MSB-aligned register buf[39:0]; valid bits occupy buf[39:40-bit_level]; rbsp_out = buf[39:16] combinationally.
REQ-014 Bits in buf below the valid region are zero.
REQ-015 nalu_byte_ready = !rst && ena && !nal_start && (bit_level <= 32); derived from registered level only, not from forward_len_in.
REQ-016 A consume is legal when ena && rbsp_valid && 1 <= forward_len_in <= 24.
  - On a legal consume, buf shifts left by forward_len_in with zero fill.
REQ-017 A forward_len_in value of 25..31, or a nonzero value while rbsp_valid = 0, is illegal.
  - Illegal request: no consume; protocol_err set until rst or nal_start.
  - The value 31 (-1 trailing marker) falls under this rule.
REQ-018 Accepted byte: written at bit position (bit_level - consumed) below the MSB, in the same cycle as any consume.
  - bit_level_next = bit_level - consumed + 8 (appended) or + 0 (dropped).
REQ-019 Throughput: one byte accepted per cycle and one consume per cycle, both in the same cycle.
  - Latency from byte acceptance to visibility in rbsp_out/bit_level: 1 cycle.
REQ-020 Emulation prevention (see REQ-027): zero_cnt (2 bits, saturating) counts consecutive accepted 0x00 bytes.
  - A byte 0x03 accepted while zero_cnt = 2 is dropped (handshake completes, nothing appended) and zero_cnt clears.
  - Any other nonzero byte clears zero_cnt.
  - A dropped 0x03 counts as a non-zero byte.
REQ-021 nal_start (with ena): bit_level, buf, zero_cnt and protocol_err clear next cycle; any consume that cycle is ignored; no byte is accepted that cycle.
REQ-022 rbsp_valid = (bit_level >= 24); registered-level based; no combinational path from forward_len_in to any output except through registers.
REQ-023 When ena is low: inputs are ignored, ready is low, and outputs hold.

Reset
REQ-024 While rst is high at a clock edge: buf = 0, bit_level = 0, zero_cnt = 0, protocol_err = 0.
REQ-025 While rst is high: rbsp_out = 0, rbsp_valid = 0, nalu_byte_ready = 0.
REQ-026 Reset mid-stream discards all held bits; the first byte after reset is treated as the start of a payload with zero_cnt = 0.

Configuration
REQ-027 Macro RBSP_EPB_REMOVE_EN.
  - Defined: REQ-020 emulation-prevention removal is active.
  - Undefined: every accepted byte is appended unchanged, zero_cnt logic is absent, and 0x03 bytes are retained.

Verification
REQ-028 Reset, then bytes A5 3C 0F with forward_len 0 -> after the third accept: rbsp_out = 24'hA53C0F, bit_level = 24, rbsp_valid = 1.
REQ-029 With 40 bits held, continuous valid bytes and forward_len = 5 each cycle -> ready stays low until bit_level <= 32.
  - Following that, byte and consume occur in the same cycle; bit_level changes by +3 per cycle.
  - Window contents match a software bit-queue model.
REQ-030 Bytes 00 00 03 01 FF, macro defined -> bit_level = 32 and rbsp_out = 24'h000001.
  - Same stimulus with macro undefined -> bit_level = 40 and rbsp_out = 24'h000003.
REQ-031 Bytes 00 00 00 03, macro defined -> 0x03 is dropped (zero_cnt saturated at 2); bit_level = 24, rbsp_out = 24'h000000.
REQ-032 forward_len = 31 with rbsp_valid = 1 -> no shift and protocol_err = 1; a later nal_start pulse -> protocol_err = 0 and bit_level = 0.
REQ-033 rst asserted mid-stream with bit_level = 17 while a byte is offered -> next cycle bit_level = 0, rbsp_out = 0, and the byte is not accepted.

Source files
------------

// File: rtl/rbsp_buffer.sv
// rtl/rbsp_buffer.sv - 40-bit MSB-aligned RBSP bit window fed by NAL payload bytes.
// Define RBSP_EPB_REMOVE_EN to strip emulation-prevention 0x03 bytes after two zero bytes.
module rbsp_buffer (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic        nal_start,
  input  logic [7:0]  nalu_byte_in,
  input  logic        nalu_byte_valid,
  output logic        nalu_byte_ready,
  input  logic [4:0]  forward_len_in,
  output logic [23:0] rbsp_out,
  output logic        rbsp_valid,
  output logic [5:0]  bit_level,
  output logic        protocol_err
);

  logic [39:0] data_q, data_d;
  logic [5:0]  level_q, level_d;
  logic        err_q, err_d;

  logic        held_valid;
  logic        ready;
  logic        accept;
  logic        fwd_illegal;
  logic        consume;
  logic        drop;
  logic [5:0]  cons_len;
  logic [5:0]  level_after;
  logic [39:0] shifted;
  logic [39:0] placed;

`ifdef RBSP_EPB_REMOVE_EN
  logic [1:0]  zero_cnt_q, zero_cnt_d;
`endif

  always_comb begin
    held_valid  = (level_q >= 6'd24);
    ready       = !rst && ena && !nal_start && (level_q <= 6'd32);
    accept      = nalu_byte_valid && ready;
    fwd_illegal = (forward_len_in >= 5'd25) || ((forward_len_in != 5'd0) && !held_valid);
    consume     = ena && !nal_start && !fwd_illegal && (forward_len_in != 5'd0);
    cons_len    = consume ? {1'b0, forward_len_in} : 6'd0;
    level_after = level_q - cons_len;
    shifted     = data_q << cons_len;
    // level_after never exceeds 32 when a byte is accepted, so the byte always fits.
    placed      = {nalu_byte_in, 32'd0} >> level_after;

`ifdef RBSP_EPB_REMOVE_EN
    drop       = accept && (zero_cnt_q == 2'd2) && (nalu_byte_in == 8'h03);
    zero_cnt_d = zero_cnt_q;
    if (ena && nal_start) begin
      zero_cnt_d = 2'd0;
    end else if (accept) begin
      if (nalu_byte_in == 8'h00) begin
        zero_cnt_d = (zero_cnt_q == 2'd2) ? 2'd2 : zero_cnt_q + 2'd1;
      end else begin
        zero_cnt_d = 2'd0;
      end
    end
`else
    drop = 1'b0;
`endif

    data_d  = data_q;
    level_d = level_q;
    err_d   = err_q;
    if (ena) begin
      if (nal_start) begin
        data_d  = 40'd0;
        level_d = 6'd0;
        err_d   = 1'b0;
      end else begin
        data_d  = shifted;
        level_d = level_after;
        if (fwd_illegal) begin
          err_d = 1'b1;
        end
        if (accept && !drop) begin
          data_d  = shifted | placed;
          level_d = level_after + 6'd8;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= 40'd0;
      level_q <= 6'd0;
      err_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      level_q <= level_d;
      err_q   <= err_d;
    end
  end

`ifdef RBSP_EPB_REMOVE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_cnt_q <= 2'd0;
    end else begin
      zero_cnt_q <= zero_cnt_d;
    end
  end
`endif

  assign nalu_byte_ready = ready;
  assign rbsp_out        = rst ? 24'd0 : data_q[39:16];
  assign rbsp_valid      = !rst && held_valid;
  assign bit_level       = level_q;
  assign protocol_err    = err_q;

endmodule

// File: tb/tb_rbsp_buffer.sv
// tb/tb_rbsp_buffer.sv - scoreboard bench for rbsp_buffer with a bit-queue reference model.
module tb_rbsp_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic        nal_start;
  logic [7:0]  nalu_byte_in;
  logic        nalu_byte_valid;
  logic        nalu_byte_ready;
  logic [4:0]  forward_len_in;
  logic [23:0] rbsp_out;
  logic        rbsp_valid;
  logic [5:0]  bit_level;
  logic        protocol_err;

  rbsp_buffer dut (
    .clk             (clk),
    .rst             (rst),
    .ena             (ena),
    .nal_start       (nal_start),
    .nalu_byte_in    (nalu_byte_in),
    .nalu_byte_valid (nalu_byte_valid),
    .nalu_byte_ready (nalu_byte_ready),
    .forward_len_in  (forward_len_in),
    .rbsp_out        (rbsp_out),
    .rbsp_valid      (rbsp_valid),
    .bit_level       (bit_level),
    .protocol_err    (protocol_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [4:0]  m;
    logic [23:0] out;
    logic [5:0]  lvl;
    logic        vld;
    logic        rdy;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  bit   mq[$];
  int   mzc = 0;
  bit   merr = 1'b0;
  bit   m_rdy = 1'b0;

  function automatic void cmp(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endfunction

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.m[4]) cmp({e.nm, ".rbsp_out"}, {8'd0, rbsp_out}, {8'd0, e.out});
      if (e.m[3]) cmp({e.nm, ".bit_level"}, {26'd0, bit_level}, {26'd0, e.lvl});
      if (e.m[2]) cmp({e.nm, ".rbsp_valid"}, {31'd0, rbsp_valid}, {31'd0, e.vld});
      if (e.m[1]) cmp({e.nm, ".ready"}, {31'd0, nalu_byte_ready}, {31'd0, e.rdy});
      if (e.m[0]) cmp({e.nm, ".protocol_err"}, {31'd0, protocol_err}, {31'd0, e.err});
    end
  end

  // Advances the reference model across one clock edge using the inputs the DUT saw.
  function automatic void model_update();
    bit rdy;
    bit vld;
    bit drop;
    if (rst) begin
      mq.delete();
      mzc  = 0;
      merr = 1'b0;
    end else if (ena) begin
      if (nal_start) begin
        mq.delete();
        mzc  = 0;
        merr = 1'b0;
      end else begin
        rdy = (mq.size() <= 32);
        vld = (mq.size() >= 24);
        if (forward_len_in >= 25 || (forward_len_in != 0 && !vld)) begin
          merr = 1'b1;
        end else begin
          for (int i = 0; i < int'(forward_len_in); i++) void'(mq.pop_front());
        end
        if (nalu_byte_valid && rdy) begin
          drop = 1'b0;
`ifdef RBSP_EPB_REMOVE_EN
          if (mzc == 2 && nalu_byte_in == 8'h03) drop = 1'b1;
          if (nalu_byte_in == 8'h00) mzc = (mzc == 2) ? 2 : mzc + 1;
          else mzc = 0;
`endif
          if (!drop) begin
            for (int i = 7; i >= 0; i--) mq.push_back(nalu_byte_in[i]);
          end
        end
      end
    end
  endfunction

  function automatic void push_model();
    exp_t e;
    e.nm  = "model";
    e.m   = 5'b11111;
    e.out = 24'd0;
    for (int i = 0; i < 24; i++) begin
      if (i < mq.size()) e.out[23-i] = mq[i];
    end
    if (rst) e.out = 24'd0;
    e.lvl = 6'(mq.size());
    e.vld = !rst && (mq.size() >= 24);
    e.rdy = !rst && ena && !nal_start && (mq.size() <= 32);
    e.err = merr;
    m_rdy = e.rdy;
    exp_q.push_back(e);
  endfunction

  task automatic step(input logic r, input logic e, input logic s, input logic v,
                      input logic [7:0] b, input logic [4:0] f);
    @(posedge clk);
    model_update();
    #1;
    rst             = r;
    ena             = e;
    nal_start       = s;
    nalu_byte_valid = v;
    nalu_byte_in    = b;
    forward_len_in  = f;
    push_model();
  endtask

  task automatic byte_in(input logic [7:0] b);
    step(1'b0, 1'b1, 1'b0, 1'b1, b, 5'd0);
  endtask

  task automatic idle();
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0);
  endtask

  task automatic hand(input string nm, input logic [4:0] m, input logic [23:0] out,
                      input logic [5:0] lvl, input logic vld, input logic rdy, input logic err);
    exp_t e;
    e.nm = nm; e.m = m; e.out = out; e.lvl = lvl; e.vld = vld; e.rdy = rdy; e.err = err;
    exp_q.push_back(e);
  endtask

  int lv_tab[10] = '{40, 35, 30, 33, 28, 31, 34, 29, 32, 35};

  initial begin
    logic [7:0] bv;
    rst = 1'b1; ena = 1'b0; nal_start = 1'b0;
    nalu_byte_in = 8'h00; nalu_byte_valid = 1'b0; forward_len_in = 5'd0;

    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'h77, 5'd0);
    hand("reset", 5'b11111, 24'h000000, 6'd0, 1'b0, 1'b0, 1'b0);

    // Three bytes with no consume fill exactly one window.
    byte_in(8'hA5);
    byte_in(8'h3C);
    hand("latency", 5'b11000, 24'hA50000, 6'd8, 1'b0, 1'b0, 1'b0);
    byte_in(8'h0F);
    idle();
    hand("fill24", 5'b11111, 24'hA53C0F, 6'd24, 1'b1, 1'b1, 1'b0);

    // Full buffer drained by 5 bits per cycle while bytes are offered continuously.
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0);
    byte_in(8'h11); byte_in(8'h22); byte_in(8'h33); byte_in(8'h44); byte_in(8'h55);
    bv = 8'h66;
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1, bv, 5'd5);
      hand("stream", 5'b01010, 24'h0, 6'(lv_tab[k]), 1'b0, (lv_tab[k] <= 32), 1'b0);
      if (k == 0) hand("full40", 5'b10100, 24'h112233, 6'd0, 1'b1, 1'b0, 1'b0);
      if (m_rdy) bv = bv + 8'h11;
    end

    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0);
    byte_in(8'h00); byte_in(8'h00); byte_in(8'h03); byte_in(8'h01); byte_in(8'hFF);
    idle();
`ifdef RBSP_EPB_REMOVE_EN
    hand("epb_seq1", 5'b11110, 24'h000001, 6'd32, 1'b1, 1'b1, 1'b0);
`else
    hand("epb_seq1", 5'b11110, 24'h000003, 6'd40, 1'b1, 1'b0, 1'b0);
`endif

    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0);
    byte_in(8'h00); byte_in(8'h00); byte_in(8'h00); byte_in(8'h03);
    idle();
`ifdef RBSP_EPB_REMOVE_EN
    hand("epb_seq2", 5'b11110, 24'h000000, 6'd24, 1'b1, 1'b1, 1'b0);
`else
    hand("epb_seq2", 5'b11110, 24'h000000, 6'd32, 1'b1, 1'b1, 1'b0);
`endif

    // Trailing marker value 31 is rejected and latches the error until nal_start.
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 5'd31);
    idle();
`ifdef RBSP_EPB_REMOVE_EN
    hand("fwd31", 5'b01001, 24'h0, 6'd24, 1'b0, 1'b0, 1'b1);
`else
    hand("fwd31", 5'b01001, 24'h0, 6'd32, 1'b0, 1'b0, 1'b1);
`endif
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'hAA, 5'd5);
    hand("nal_start_rdy", 5'b00011, 24'h0, 6'd0, 1'b0, 1'b0, 1'b1);
    idle();
    hand("nal_start_clr", 5'b11111, 24'h000000, 6'd0, 1'b0, 1'b1, 1'b0);

    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 5'd3);
    idle();
    hand("fwd_no_valid", 5'b01001, 24'h0, 6'd0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 5'd0);
    idle();
    hand("err_clear", 5'b00001, 24'h0, 6'd0, 1'b0, 1'b0, 1'b0);

    // Reach 17 bits, hold with ena low, then reset while a byte is offered.
    byte_in(8'hC3); byte_in(8'h5A); byte_in(8'h96);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 5'd7);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'hE7, 5'd9);
    hand("lvl17", 5'b11111, 24'hAD4B00, 6'd17, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'hE7, 5'd0);
    hand("ena_low_hold", 5'b01001, 24'h0, 6'd17, 1'b0, 1'b0, 1'b0);
    hand("in_reset", 5'b10110, 24'h000000, 6'd0, 1'b0, 1'b0, 1'b0);
    idle();
    hand("after_reset", 5'b11111, 24'h000000, 6'd0, 1'b0, 1'b1, 1'b0);
    byte_in(8'h81);
    idle();
    hand("first_after_reset", 5'b11100, 24'h810000, 6'd8, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) cmp("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
